// File: rtl/mem_stage_wait.sv
// MIPS32 MEM stage: byte-addressed data RAM, sub-word loads/stores, wait states.
// Optional MEM_ACCESS_CNT_EN adds saturating load_cnt/store_cnt outputs.
module mem_stage_wait #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int RD_W        = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [1:0]      size,
    input  logic            load_unsigned,
    input  logic [31:0]     aluOut,
    input  logic [31:0]     writeData,
    input  logic [RD_W-1:0] rd,
    output logic            out_valid,
    output logic [31:0]     readData,
    output logic [31:0]     aluOutToWB,
    output logic [RD_W-1:0] rdToWB,
    output logic            RegWriteToWB,
    output logic            MemtoRegToWB,
    output logic            misalign
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [31:0]     load_cnt,
    output logic [31:0]     store_cnt
`endif
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef struct packed {
        logic            mem_to_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      size;
        logic            load_unsigned;
        logic [31:0]     alu;
        logic [31:0]     wdata;
        logic [RD_W-1:0] rd;
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    op_t        op_in, op_q, cur;
    logic       latch;
    logic       complete;

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      rword;
    logic [31:0]      rshift;
    logic [7:0]       rbyte;
    logic [15:0]      rhalf;
    logic [31:0]      ld_data;
    logic [3:0]       be;
    logic [31:0]      sdata;
    logic             is_mem;
    logic             misal;
    logic             do_store;
    logic             do_load;

    assign op_in = '{
        mem_to_reg:    MemtoReg,
        reg_write:     RegWrite,
        mem_read:      MemRead,
        mem_write:     MemWrite,
        size:          size,
        load_unsigned: load_unsigned,
        alu:           aluOut,
        wdata:         writeData,
        rd:            rd
    };

    // While waiting, the latched op drives the access, not the EX inputs.
    assign cur = (state_q == S_WAIT) ? op_q : op_in;

    assign idx    = cur.alu[IDX_W+1:2];
    assign lane   = cur.alu[1:0];
    assign is_mem = cur.mem_read | cur.mem_write;

    always_comb begin
        misal = 1'b0;
        if (is_mem) begin
            unique case (1'b1)
                cur.size == 2'b00: misal = 1'b0;
                cur.size == 2'b01: misal = lane[0];
                default:           misal = (lane != 2'b00);
            endcase
        end
    end

    assign do_store = complete & cur.mem_write & ~misal;
    assign do_load  = complete & cur.mem_read & ~cur.mem_write & ~misal;

    always_comb begin
        be    = 4'b0000;
        sdata = cur.wdata;
        unique case (1'b1)
            cur.size == 2'b00: begin
                be    = 4'b0001 << lane;
                sdata = {4{cur.wdata[7:0]}};
            end
            cur.size == 2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                sdata = {2{cur.wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                sdata = cur.wdata;
            end
        endcase
    end

    assign rword  = mem[idx];
    assign rshift = rword >> {lane, 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ld_data = rword;
        unique case (1'b1)
            cur.size == 2'b00: begin
                if (cur.load_unsigned) ld_data = {24'd0, rbyte};
                else                   ld_data = {{24{rbyte[7]}}, rbyte};
            end
            cur.size == 2'b01: begin
                if (cur.load_unsigned) ld_data = {16'd0, rhalf};
                else                   ld_data = {{16{rhalf[15]}}, rhalf};
            end
            default: ld_data = rword;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        latch    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!is_mem || misal || WS == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        cnt_d   = WS;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) op_q <= op_in;
        end
    end

    // RAM has no reset so an aborted op can never disturb it.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= sdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            readData     <= 32'd0;
            aluOutToWB   <= 32'd0;
            rdToWB       <= '0;
            RegWriteToWB <= 1'b0;
            MemtoRegToWB <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            out_valid <= complete;
            if (complete) begin
                readData     <= do_load ? ld_data : 32'd0;
                aluOutToWB   <= cur.alu;
                rdToWB       <= cur.rd;
                RegWriteToWB <= cur.reg_write & ~misal;
                MemtoRegToWB <= cur.mem_to_reg;
                misalign     <= misal;
            end
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt  <= 32'd0;
            store_cnt <= 32'd0;
        end else begin
            if (do_load && load_cnt != 32'hFFFF_FFFF)
                load_cnt <= load_cnt + 32'd1;
            if (do_store && store_cnt != 32'hFFFF_FFFF)
                store_cnt <= store_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_wait.sv
// Directed bench for mem_stage_wait: one zero-wait and one 3-wait instance.
module tb_mem_stage_wait;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v3 = 1'b0;
    logic        MemtoReg = 1'b0, RegWrite = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] aluOut = 32'd0, writeData = 32'd0;
    logic [4:0]  rd = 5'd0;

    logic        rdy0, ov0, rw0, mtr0, mis0;
    logic [31:0] rdat0, alu0;
    logic [4:0]  rdo0;
    logic        rdy3, ov3, rw3, mtr3, mis3;
    logic [31:0] rdat3, alu3;
    logic [4:0]  rdo3;

    int checks = 0;
    int failures = 0;

    logic        g_ov, g_ovn, g_rw, g_mtr, g_mis;
    logic [31:0] g_rd, g_alu;
    logic [4:0]  g_rdo;
    int          g_lat, g_low;

    always #5 clk = ~clk;

    mem_stage_wait #(.DEPTH(256), .WAIT_STATES(0), .RD_W(5)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .size(size), .load_unsigned(load_unsigned),
        .aluOut(aluOut), .writeData(writeData), .rd(rd),
        .out_valid(ov0), .readData(rdat0), .aluOutToWB(alu0),
        .rdToWB(rdo0), .RegWriteToWB(rw0), .MemtoRegToWB(mtr0),
        .misalign(mis0)
    );

    mem_stage_wait #(.DEPTH(256), .WAIT_STATES(3), .RD_W(5)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .size(size), .load_unsigned(load_unsigned),
        .aluOut(aluOut), .writeData(writeData), .rd(rd),
        .out_valid(ov3), .readData(rdat3), .aluOutToWB(alu3),
        .rdToWB(rdo3), .RegWriteToWB(rw3), .MemtoRegToWB(mtr3),
        .misalign(mis3)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op; valid is held until the result appears.
    task automatic run_op(input bit sel, input bit mr, input bit mw,
                          input bit mtr, input bit rw, input logic [1:0] sz,
                          input bit lu, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r);
        int n;
        @(negedge clk);
        MemRead = mr; MemWrite = mw; MemtoReg = mtr; RegWrite = rw;
        size = sz; load_unsigned = lu; aluOut = a; writeData = wd; rd = r;
        if (sel) v3 = 1'b1;
        else     v0 = 1'b1;
        n = 0;
        while (!(sel ? rdy3 : rdy0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        g_lat = 1;
        g_low = 0;
        while (!(sel ? ov3 : ov0) && g_lat < 40) begin
            if (!(sel ? rdy3 : rdy0)) g_low++;
            @(negedge clk);
            g_lat++;
        end
        v0 = 1'b0;
        v3 = 1'b0;
        g_ov  = sel ? ov3 : ov0;
        g_rd  = sel ? rdat3 : rdat0;
        g_alu = sel ? alu3 : alu0;
        g_rdo = sel ? rdo3 : rdo0;
        g_rw  = sel ? rw3 : rw0;
        g_mtr = sel ? mtr3 : mtr0;
        g_mis = sel ? mis3 : mis0;
        @(negedge clk);
        g_ovn = sel ? ov3 : ov0;
    endtask

    initial begin
        int cnt;
        @(negedge clk);
        @(negedge clk);
        check("rst_rdy0", rdy0, 1);
        check("rst_ov0", ov0, 0);
        check("rst_rdat0", rdat0, 0);
        check("rst_rdy3", rdy3, 1);
        check("rst_mis3", mis3, 0);
        rst = 1'b0;

        run_op(0, 0, 1, 0, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        check("sw_valid", g_ov, 1);
        check("sw_lat", g_lat, 1);
        check("sw_rdata", g_rd, 0);
        check("sw_pulse", g_ovn, 0);

        run_op(0, 1, 0, 1, 1, 2'b10, 0, 32'h10, 32'h0, 5'd5);
        check("lw_data", g_rd, 32'hDEADBEEF);
        check("lw_mis", g_mis, 0);
        check("lw_rd", g_rdo, 5);
        check("lw_rw", g_rw, 1);
        check("lw_mtr", g_mtr, 1);

        run_op(0, 0, 1, 0, 0, 2'b00, 0, 32'h11, 32'h1234567F, 5'd0);
        run_op(0, 1, 0, 1, 1, 2'b00, 0, 32'h11, 32'h0, 5'd6);
        check("lb_11", g_rd, 32'h0000007F);
        run_op(0, 1, 0, 1, 1, 2'b01, 0, 32'h12, 32'h0, 5'd6);
        check("lh_12", g_rd, 32'hFFFFDEAD);
        run_op(0, 1, 0, 1, 1, 2'b00, 1, 32'h13, 32'h0, 5'd6);
        check("lbu_13", g_rd, 32'h000000DE);

        run_op(0, 1, 0, 1, 1, 2'b01, 0, 32'h13, 32'h0, 5'd7);
        check("mis_flag", g_mis, 1);
        check("mis_rw", g_rw, 0);
        check("mis_rdata", g_rd, 0);
        run_op(0, 0, 1, 0, 0, 2'b10, 0, 32'h12, 32'hFFFFFFFF, 5'd0);
        check("mis_sw_flag", g_mis, 1);
        run_op(0, 1, 0, 1, 1, 2'b10, 0, 32'h10, 32'h0, 5'd7);
        check("lw_after_mis", g_rd, 32'hDEAD7FEF);
        run_op(0, 1, 0, 1, 1, 2'b00, 0, 32'h10, 32'h0, 5'd7);
        check("lb_10", g_rd, 32'hFFFFFFEF);
        run_op(0, 1, 0, 1, 1, 2'b01, 1, 32'h10, 32'h0, 5'd7);
        check("lhu_10", g_rd, 32'h00007FEF);

        run_op(0, 0, 0, 0, 1, 2'b10, 0, 32'h12345677, 32'h0, 5'd3);
        check("alu_pass", g_alu, 32'h12345677);
        check("alu_mis", g_mis, 0);
        check("alu_rdata", g_rd, 0);
        check("alu_rw", g_rw, 1);

        run_op(0, 0, 1, 0, 0, 2'b10, 0, 32'h400, 32'h1, 5'd0);
        run_op(0, 1, 0, 1, 1, 2'b10, 0, 32'h0, 32'h0, 5'd1);
        check("wrap", g_rd, 32'h00000001);

        run_op(0, 1, 1, 0, 0, 2'b10, 0, 32'h20, 32'hA5A5A5A5, 5'd0);
        check("rw_both_rdata", g_rd, 0);
        run_op(0, 0, 1, 0, 0, 2'b01, 0, 32'h22, 32'h0000BEEF, 5'd0);
        run_op(0, 1, 0, 1, 1, 2'b10, 0, 32'h20, 32'h0, 5'd2);
        check("sh_merge", g_rd, 32'hBEEFA5A5);

        run_op(1, 0, 1, 0, 0, 2'b10, 0, 32'h40, 32'h11223344, 5'd0);
        check("w3_sw_lat", g_lat, 4);
        check("w3_sw_low", g_low, 3);
        run_op(1, 1, 0, 1, 1, 2'b10, 0, 32'h40, 32'h0, 5'd9);
        check("w3_lw_lat", g_lat, 4);
        check("w3_lw_low", g_low, 3);
        check("w3_lw_data", g_rd, 32'h11223344);
        check("w3_lw_rd", g_rdo, 9);
        check("w3_lw_pulse", g_ovn, 0);
        run_op(1, 1, 0, 1, 1, 2'b10, 0, 32'h41, 32'h0, 5'd9);
        check("w3_mis_lat", g_lat, 1);
        check("w3_mis_flag", g_mis, 1);
        run_op(1, 1, 0, 1, 1, 2'b00, 0, 32'h42, 32'h0, 5'd9);
        check("w3_lb_42", g_rd, 32'h00000022);

        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; RegWrite = 1'b0; MemtoReg = 1'b0;
        size = 2'b10; aluOut = 32'h40; writeData = 32'h99;
        v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rdy", rdy3, 1);
        check("abort_ov", ov3, 0);
        check("abort_rdata", rdat3, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov3) cnt++;
        end
        check("abort_no_valid", cnt, 0);
        run_op(1, 1, 0, 1, 1, 2'b10, 0, 32'h40, 32'h0, 5'd4);
        check("abort_old_data", g_rd, 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
